pio_cmd_bridge: RTL and testbench

PIO_CMD_BRIDGE -- requirements
Module: pio_cmd_bridge

---
 rtl/pio_cmd_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_pio_cmd_bridge.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_cmd_bridge.sv
// pio_cmd_bridge
//   Bridges HPS parallel-I/O writes to a coprocessor command port. A rising
//   edge on pio_enable submits pio_instruct into a small command FIFO; a
//   three-state FSM (IDLE/ISSUE/WAIT) hands each queued word to the
//   coprocessor with a valid/ready handshake and waits for its done pulse.
//   An all-ones instruction is a CLEAR command: it is never queued, it flushes
//   the FIFO and clears the done/error flags.
//
//   Optional feature macro: PIO_CMD_BRIDGE_TIMEOUT_EN
//     defined   -> WAIT watchdog; after TIMEOUT_CYC cycles without cop_done the
//                  command completes with error, result all ones.
//     undefined -> WAIT lasts until cop_done; no watchdog logic.
//
// Ports
//   clk_clk        in   1        clock, rising edge
//   reset_reset_n  in   1        asynchronous active-low reset
//   pio_instruct   in   INSTR_W  instruction word from HPS
//   pio_enable     in   1        submit strobe (rising edge submits)
//   pio_dataout    out  DATA_W   last captured result
//   pio_flags      out  4        {busy, full, error, done}
//   cop_instr      out  INSTR_W  instruction to coprocessor
//   cop_valid      out  1        cop_instr valid
//   cop_ready      in   1        coprocessor accepts cop_instr
//   cop_done       in   1        one-cycle completion pulse
//   cop_result     in   DATA_W   result, qualified by cop_done
//   cop_error      in   1        error, qualified by cop_done
module pio_cmd_bridge #(
  parameter int INSTR_W     = 29,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [INSTR_W-1:0] pio_instruct,
  input  logic               pio_enable,
  output logic [DATA_W-1:0]  pio_dataout,
  output logic [3:0]         pio_flags,
  output logic [INSTR_W-1:0] cop_instr,
  output logic               cop_valid,
  input  logic               cop_ready,
  input  logic               cop_done,
  input  logic [DATA_W-1:0]  cop_result,
  input  logic               cop_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Elaboration-time parameter sanity checks
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state_r, next_state_s;
  logic               enable_q_r;
  logic               armed_r;
  logic [INSTR_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [DATA_W-1:0]  dataout_r;
  logic               done_r, error_r;

  logic edge_s, clear_s, push_req_s, push_ok_s, drop_s, pop_s;
  logic full_s, busy_s, complete_s, timeout_s;

  // armed_r masks the first cycle after reset so an enable held high through
  // release is only sampled into enable_q_r, never seen as an edge.
  assign edge_s     = pio_enable & ~enable_q_r & armed_r;
  assign clear_s    = edge_s & (pio_instruct == {INSTR_W{1'b1}});
  assign push_req_s = edge_s & ~clear_s;
  assign full_s     = (count_r == DEPTH_C);
  assign busy_s     = (state_r != ST_IDLE) | (count_r != {CNT_W{1'b0}});
  assign pop_s      = (state_r == ST_ISSUE) & cop_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok_s  = push_req_s & (~full_s | pop_s);
  assign drop_s     = push_req_s & full_s & ~pop_s;
  assign complete_s = (state_r == ST_WAIT) & cop_done;

`ifdef PIO_CMD_BRIDGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt_r;

  // Watchdog: counts cycles spent in WAIT, restarts on every entry to WAIT
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else if (state_r != ST_WAIT) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end
  end

  assign timeout_s = (state_r == ST_WAIT) & ~cop_done & (wd_cnt_r == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Edge-detect history and post-reset arming
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      enable_q_r <= 1'b0;
      armed_r    <= 1'b0;
    end else begin
      enable_q_r <= pio_enable;
      armed_r    <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because count_r gates all reads
  always_ff @(posedge clk_clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= pio_instruct;
    end
  end

  // FIFO pointers and occupancy; CLEAR flushes even if a pop coincides
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clear_s) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; CLEAR pulls ISSUE back to IDLE so it never
  // presents a flushed head
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((count_r != {CNT_W{1'b0}}) && !clear_s) next_state_s = ST_ISSUE;
        else                                          next_state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (cop_ready)    next_state_s = ST_WAIT;
        else if (clear_s) next_state_s = ST_IDLE;
        else              next_state_s = ST_ISSUE;
      end
      ST_WAIT: begin
        if (cop_done || timeout_s) next_state_s = ST_IDLE;
        else                       next_state_s = ST_WAIT;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    cop_valid = 1'b0;
    cop_instr = {INSTR_W{1'b0}};
    case (state_r)
      ST_ISSUE: begin
        cop_valid = 1'b1;
        cop_instr = mem_r[rd_ptr_r];
      end
      default: begin
        cop_valid = 1'b0;
        cop_instr = {INSTR_W{1'b0}};
      end
    endcase
  end

  // Result and sticky status flags; a completion in the same cycle as a
  // push or CLEAR wins so its done is not lost
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      dataout_r <= {DATA_W{1'b0}};
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      if (complete_s) begin
        dataout_r <= cop_result;
        done_r    <= 1'b1;
        error_r   <= (error_r & ~clear_s) | cop_error;
      end else if (timeout_s) begin
        dataout_r <= {DATA_W{1'b1}};
        done_r    <= 1'b1;
        error_r   <= 1'b1;
      end else begin
        dataout_r <= dataout_r;
        done_r    <= done_r & ~clear_s & ~push_ok_s;
        error_r   <= (error_r & ~clear_s) | drop_s;
      end
    end
  end

  assign pio_dataout = dataout_r;
  assign pio_flags   = {busy_s, full_s, error_r, done_r};

endmodule

// File: tb/tb_pio_cmd_bridge.sv
module tb_pio_cmd_bridge;

  localparam int IW = 29;
  localparam int DW = 8;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic [IW-1:0] pio_instruct;
  logic          pio_enable;
  logic [DW-1:0] pio_dataout;
  logic [3:0]    pio_flags;
  logic [IW-1:0] cop_instr;
  logic          cop_valid;
  logic          cop_ready;
  logic          cop_done;
  logic [DW-1:0] cop_result;
  logic          cop_error;

  int n_cmp  = 0;
  int n_err  = 0;
  int hs_cnt = 0;
  logic [IW-1:0] exp_q[$];

  pio_cmd_bridge #(
    .INSTR_W(IW), .DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .pio_instruct(pio_instruct), .pio_enable(pio_enable),
    .pio_dataout(pio_dataout), .pio_flags(pio_flags),
    .cop_instr(cop_instr), .cop_valid(cop_valid), .cop_ready(cop_ready),
    .cop_done(cop_done), .cop_result(cop_result), .cop_error(cop_error)
  );

  always #5 clk_clk = ~clk_clk;

  // Scoreboard: every handshake must match the oldest expected instruction
  always @(negedge clk_clk) begin : monitor
    logic [IW-1:0] e;
    if (reset_reset_n && cop_valid && cop_ready) begin
      hs_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: issued %h, expected nothing", cop_instr);
      end else begin
        e = exp_q.pop_front();
        if (cop_instr !== e) begin
          n_err++;
          $display("FAIL sb_order: issued %h, expected %h", cop_instr, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic chk_flags(input string name, input logic [3:0] exp);
    n_cmp++;
    if (pio_flags !== exp) begin
      n_err++;
      $display("FAIL %s: flags %b, expected %b", name, pio_flags, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] exp);
    n_cmp++;
    if (pio_dataout !== exp) begin
      n_err++;
      $display("FAIL %s: dataout %h, expected %h", name, pio_dataout, exp);
    end
  endtask

  task automatic chk_valid(input string name, input logic exp);
    n_cmp++;
    if (cop_valid !== exp) begin
      n_err++;
      $display("FAIL %s: cop_valid %b, expected %b", name, cop_valid, exp);
    end
  endtask

  // One-cycle high strobe, then one low cycle
  task automatic submit(input logic [IW-1:0] w, input bit expect_issue);
    pio_instruct = w;
    pio_enable   = 1'b1;
    if (expect_issue) exp_q.push_back(w);
    step(1);
    pio_enable = 1'b0;
    step(1);
  endtask

  task automatic complete(input logic [DW-1:0] r);
    cop_done   = 1'b1;
    cop_result = r;
    step(1);
    cop_done   = 1'b0;
    cop_result = 8'h00;
  endtask

  // Issue n commands with cop_ready high; the result is derived from the word
  task automatic drain(input int n);
    int guard;
    logic [DW-1:0] r;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!cop_valid && guard < 20) begin
        step(1);
        guard++;
      end
      n_cmp++;
      if (!cop_valid) begin
        n_err++;
        $display("FAIL drain_wait: cop_valid %b, expected 1 within 20 cycles", cop_valid);
      end else begin
        r = cop_instr[7:0] ^ 8'h3C;
        step(1);
        complete(r);
        chk_data("drain_result", r);
      end
    end
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    pio_enable    = 1'b1;
    pio_instruct  = 29'h0000055;
    step(3);
    chk_flags("reset_flags", 4'b0000);
    chk_data("reset_data", 8'h00);
    chk_valid("reset_valid", 1'b0);
    n_cmp++;
    if (cop_instr !== 29'h0) begin
      n_err++;
      $display("FAIL reset_instr: cop_instr %h, expected 0", cop_instr);
    end
    reset_reset_n = 1'b1;
    step(4);
    chk_flags("enable_held_no_edge", 4'b0000);
    chk_valid("enable_held_valid", 1'b0);
    pio_enable = 1'b0;
    step(2);
  endtask

  task automatic test_single();
    cop_ready    = 1'b1;
    pio_instruct = 29'h0000123;
    pio_enable   = 1'b1;
    exp_q.push_back(29'h0000123);
    step(1);
    chk_valid("latency_edge1", 1'b0);
    pio_enable = 1'b0;
    step(1);
    chk_valid("latency_edge2", 1'b1);
    n_cmp++;
    if (cop_instr !== 29'h0000123) begin
      n_err++;
      $display("FAIL single_instr: cop_instr %h, expected 0000123", cop_instr);
    end
    step(1);
    chk_valid("single_wait_valid", 1'b0);
    step(1);
    complete(8'h5A);
    chk_data("single_data", 8'h5A);
    chk_flags("single_flags", 4'b0001);
    complete(8'h33);
    chk_data("done_outside_wait", 8'h5A);
  endtask

  task automatic test_overflow();
    int hs0;
    cop_ready = 1'b0;
    for (int i = 0; i < 4; i++) submit(29'h0000100 + 29'(i), 1'b1);
    chk_flags("overflow_full", 4'b1100);
    submit(29'h0000104, 1'b0);
    chk_flags("overflow_drop", 4'b1110);
    n_cmp++;
    if (cop_instr !== 29'h0000100 || cop_valid !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_head: cop_instr %h valid %b, expected 0000100 valid 1", cop_instr, cop_valid);
    end
    hs0 = hs_cnt;
    cop_ready = 1'b1;
    drain(4);
    step(5);
    n_cmp++;
    if (hs_cnt - hs0 != 4) begin
      n_err++;
      $display("FAIL overflow_count: issued %0d, expected 4", hs_cnt - hs0);
    end
    chk_flags("overflow_after", 4'b0011);
  endtask

  task automatic test_clear();
    cop_ready = 1'b0;
    for (int i = 0; i < 3; i++) submit(29'h0000200 + 29'(i), 1'b0);
    chk_flags("clear_before", 4'b1010);
    submit({IW{1'b1}}, 1'b0);
    chk_flags("clear_flags", 4'b0000);
    cop_ready = 1'b1;
    step(8);
    chk_valid("clear_no_issue", 1'b0);
    submit(29'h0000301, 1'b1);
    step(1);
    submit({IW{1'b1}}, 1'b0);
    chk_flags("clear_keeps_wait", 4'b1000);
    complete(8'h81);
    chk_data("clear_wait_result", 8'h81);
    chk_flags("clear_wait_flags", 4'b0001);
  endtask

  task automatic test_simultaneous();
    cop_ready = 1'b0;
    for (int i = 0; i < 4; i++) submit(29'h0000400 + 29'(i), 1'b1);
    chk_flags("simul_full", 4'b1100);
    pio_instruct = 29'h0000404;
    pio_enable   = 1'b1;
    cop_ready    = 1'b1;
    exp_q.push_back(29'h0000404);
    step(1);
    pio_enable = 1'b0;
    chk_flags("simul_push_pop", 4'b1100);
    chk_valid("simul_wait", 1'b0);
    complete(8'h11);
    drain(4);
    chk_flags("simul_end", 4'b0001);
  endtask

  task automatic test_back_to_back();
    cop_ready = 1'b0;
    submit(29'h0000501, 1'b1);
    submit(29'h0000502, 1'b1);
    cop_ready = 1'b1;
    step(1);
    complete(8'h22);
    chk_valid("b2b_idle", 1'b0);
    chk_flags("b2b_idle_flags", 4'b1001);
    step(1);
    chk_valid("b2b_issue", 1'b1);
    n_cmp++;
    if (cop_instr !== 29'h0000502) begin
      n_err++;
      $display("FAIL b2b_instr: cop_instr %h, expected 0000502", cop_instr);
    end
    step(1);
    complete(8'h23);
    chk_data("b2b_data", 8'h23);
    chk_flags("b2b_flags", 4'b0001);
  endtask

  task automatic test_reset_mid_wait();
    cop_ready = 1'b1;
    submit(29'h0000601, 1'b1);
    step(1);
    chk_flags("midwait_busy", 4'b1000);
    reset_reset_n = 1'b0;
    #2;
    chk_flags("async_reset_flags", 4'b0000);
    chk_data("async_reset_data", 8'h00);
    step(2);
    reset_reset_n = 1'b1;
    step(2);
    complete(8'h77);
    step(1);
    chk_flags("midwait_flags", 4'b0000);
    chk_data("midwait_data", 8'h00);
    chk_valid("midwait_valid", 1'b0);
  endtask

  task automatic test_timeout();
    cop_ready = 1'b1;
    submit(29'h0000701, 1'b1);
    step(1);
`ifdef PIO_CMD_BRIDGE_TIMEOUT_EN
    step(15);
    chk_flags("timeout_not_yet", 4'b1000);
    step(1);
    chk_flags("timeout_flags", 4'b0011);
    chk_data("timeout_data", 8'hFF);
    step(2);
    chk_valid("timeout_idle", 1'b0);
    chk_flags("timeout_idle_flags", 4'b0011);
`else
    step(40);
    chk_flags("no_timeout_wait", 4'b1000);
    complete(8'h44);
    chk_data("no_timeout_data", 8'h44);
    chk_flags("no_timeout_flags", 4'b0001);
`endif
  endtask

  initial begin
    pio_instruct = 29'h0;
    pio_enable   = 1'b0;
    cop_ready    = 1'b0;
    cop_done     = 1'b0;
    cop_result   = 8'h00;
    cop_error    = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_clear();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
